// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide engine: command codes, FSM states
// and the divide latency.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam int W_DEFAULT = 32;

  function automatic int div_lat(input int w);
    return w + 1;
  endfunction

  // W restoring steps plus one sign-fix cycle
  localparam int DIV_LAT = div_lat(W_DEFAULT);

  function automatic logic is_signed_op(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

  function automatic logic is_mul_op(input op_t o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) ||
           (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring radix-2 divider on operand magnitudes, followed by one
// cycle in which the quotient/remainder signs are applied.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         last_step,
  output logic         valid,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W + 1);

  state_t        phase, phase_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q_mag, r_mag, d_mag;
  logic          q_neg, r_neg;
  logic [W:0]    shifted, diff;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? -x : x;
  endfunction

  // diff[W] set means the trial subtraction borrowed, so the remainder is restored
  assign shifted = {r_mag, q_mag[W-1]};
  assign diff    = shifted - {1'b0, d_mag};

  always_comb begin
    phase_nxt = phase;
    case (phase)
      IDLE:    if (start) phase_nxt = DIV;
      DIV: begin
        if (flush)                 phase_nxt = IDLE;
        else if (cnt == CW'(1))    phase_nxt = FIX;
      end
      FIX:     phase_nxt = IDLE;
      default: phase_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= IDLE;
      cnt   <= '0;
      q_mag <= '0;
      r_mag <= '0;
      d_mag <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (phase == IDLE && start) begin
        cnt   <= CW'(W);
        q_mag <= mag(dividend, is_signed);
        r_mag <= '0;
        d_mag <= mag(divisor, is_signed);
        q_neg <= is_signed && (dividend[W-1] ^ divisor[W-1]);
        r_neg <= is_signed && dividend[W-1];
      end else if (phase == DIV) begin
        if (flush) begin
          cnt <= '0;
        end else begin
          cnt   <= cnt - CW'(1);
          q_mag <= {q_mag[W-2:0], ~diff[W]};
          r_mag <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
        end
      end
    end
  end

  assign busy      = (phase != IDLE);
  assign last_step = (phase == DIV) && (cnt == CW'(1));
  assign valid     = (phase == FIX);
  // most-negative / -1 yields magnitude 2^(W-1) with positive sign, which is most-negative again
  assign quot      = q_neg ? -q_mag : q_mag;
  assign rem       = r_neg ? -r_mag : r_mag;

endmodule

// File: rtl/muldiv_engine.sv
// HI/LO multiply/divide unit: fixed-latency multiply path, iterative divider,
// direct HI/LO moves.
//   state | meaning
//   IDLE  | accepting commands, MTHI/MTLO and divide-by-zero complete here
//   MUL   | product held, counting down MUL_LAT cycles to commit
//   DIV   | divider core running its W magnitude steps
//   FIX   | divider applying signs, HI/LO commit at the end of this cycle
module muldiv_engine
  import muldiv_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_LAT = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int MCW = $clog2(MUL_LAT + 1);

  state_t           state, state_nxt;
  op_t              cmd;
  logic [MCW-1:0]   mul_cnt;
  logic [2*W-1:0]   ext_a, ext_b, prod, hilo, mul_val, mul_res;
  logic             accept, acc_mul, acc_div, acc_div0, acc_mthi, acc_mtlo;
  logic             mul_commit, div_commit;
  logic             div_busy, div_last, div_valid;
  logic [W-1:0]     div_quot, div_rem;

  assign cmd      = op_t'(op);
  assign busy     = (state != IDLE);
  assign accept   = start && !busy && !flush;
  assign acc_mul  = accept && is_mul_op(cmd);
  assign acc_div  = accept && is_div_op(cmd) && (src_b != '0);
  assign acc_div0 = accept && is_div_op(cmd) && (src_b == '0);
  assign acc_mthi = accept && (cmd == OP_MTHI);
  assign acc_mtlo = accept && (cmd == OP_MTLO);

  // extend to 2W so a single truncated product serves both signed and unsigned ops
  assign ext_a = is_signed_op(cmd) ? {{W{src_a[W-1]}}, src_a} : {{W{1'b0}}, src_a};
  assign ext_b = is_signed_op(cmd) ? {{W{src_b[W-1]}}, src_b} : {{W{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;
  assign hilo  = {hi, lo};

  always_comb begin
    mul_val = prod;
    case (cmd)
      OP_MADD, OP_MADDU: mul_val = hilo + prod;
      OP_MSUB, OP_MSUBU: mul_val = hilo - prod;
      default:           mul_val = prod;
    endcase
  end

  muldiv_div_core #(.W(W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (acc_div),
    .flush     (flush),
    .is_signed (is_signed_op(cmd)),
    .dividend  (src_a),
    .divisor   (src_b),
    .busy      (div_busy),
    .last_step (div_last),
    .valid     (div_valid),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_comb begin
    state_nxt  = state;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    case (state)
      IDLE: begin
        if (acc_mul)      state_nxt = MUL;
        else if (acc_div) state_nxt = DIV;
      end
      MUL: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (mul_cnt == MCW'(1)) begin
          mul_commit = 1'b1;
          state_nxt  = IDLE;
        end
      end
      DIV: begin
        if (flush)          state_nxt = IDLE;
        else if (div_last)  state_nxt = FIX;
        else if (!div_busy) state_nxt = IDLE;
      end
      FIX: begin
        div_commit = div_valid && !flush;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mul_cnt <= '0;
      mul_res <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= mul_commit || div_commit || acc_div0;
      if (acc_mul) begin
        mul_cnt <= MCW'(MUL_LAT);
        mul_res <= mul_val;
      end else if (state == MUL) begin
        mul_cnt <= (flush || mul_commit) ? '0 : mul_cnt - MCW'(1);
      end
      if (mul_commit) begin
        {hi, lo} <= mul_res;
      end else if (div_commit) begin
        hi <= div_rem;
        lo <= div_quot;
      end else begin
        if (acc_mthi) hi <= src_a;
        if (acc_mtlo) lo <= src_a;
      end
    end
  end

endmodule
